rr_arbiter_lock: RTL and testbench

- Parametrised round-robin arbiter for the crossbar. It is the successor of the fixed 4-way slave-to-master arbiter.
- Generalised to NUM_REQ requesters. The grant is registered and held locked for a whole transfer until the owner signals release.
- Sits in front of each shared channel mux; gnt/gnt_idx drive the mux select.
- Optional watchdog forcibly reclaims a grant that is held too long.

---
 rtl/rr_arbiter_lock.sv | 149 ++++++++++++++
 tb/tb_rr_arbiter_lock.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_lock.sv
// Round-robin arbiter with a registered grant that stays locked until the owner releases it.
// Optional watchdog that reclaims a grant held too long: define ARB_TIMEOUT_EN.
module rr_arbiter_lock #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic               timeout_o
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_r, state_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [IDX_W-1:0]   last_r, last_s;
    logic               vld_r, vld_s;
    logic [IDX_W-1:0]   win_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               to_r, to_s;
`endif

    // The pointer's own index is examined last, giving it the lowest priority.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                     input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] w;
        logic             found;
        int               cand;
        w     = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last) + i) % NUM_REQ;
            if (!found && r[cand]) begin
                w     = IDX_W'(cand);
                found = 1'b1;
            end else begin
                w     = w;
            end
        end
        return w;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            idx_r   <= '0;
            vld_r   <= 1'b0;
            last_r  <= IDX_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            cnt_r   <= '0;
            to_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            idx_r   <= idx_s;
            vld_r   <= vld_s;
            last_r  <= last_s;
`ifdef ARB_TIMEOUT_EN
            cnt_r   <= cnt_s;
            to_r    <= to_s;
`endif
        end
    end

    // Next-state logic: arbitrate in IDLE, hold everything frozen in BUSY until release.
    always_comb begin
        win_s   = pick_winner(req, last_r);
        state_s = state_r;
        gnt_s   = gnt_r;
        idx_s   = idx_r;
        vld_s   = vld_r;
        last_s  = last_r;
`ifdef ARB_TIMEOUT_EN
        cnt_s   = cnt_r;
        to_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s = BUSY;
                    gnt_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
                    idx_s   = win_s;
                    vld_s   = 1'b1;
                    last_s  = win_s;
`ifdef ARB_TIMEOUT_EN
                    cnt_s   = '0;
`endif
                end else begin
                    gnt_s   = '0;
                    idx_s   = '0;
                    vld_s   = 1'b0;
                end
            end
            BUSY: begin
                if (release_i) begin
                    state_s = IDLE;
                    gnt_s   = '0;
                    idx_s   = '0;
                    vld_s   = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_s = IDLE;
                    gnt_s   = '0;
                    idx_s   = '0;
                    vld_s   = 1'b0;
                    to_s    = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
`else
                end else begin
                    state_s = BUSY;
`endif
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = '0;
                idx_s   = '0;
                vld_s   = 1'b0;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        gnt     = gnt_r;
        gnt_idx = idx_r;
        gnt_vld = vld_r;
`ifdef ARB_TIMEOUT_EN
        timeout_o = to_r;
`else
        timeout_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Scoreboard bench for rr_arbiter_lock: stimulus queues expected grants, a monitor checks each new grant.
module tb_rr_arbiter_lock;

    localparam int N = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TO    = 8;
    localparam int HOLD2 = 5;
`else
    localparam int TO    = 256;
    localparam int HOLD2 = 10;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         release_i = 1'b0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_vld;
    logic         timeout_o;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    rr_arbiter_lock #(.NUM_REQ(N), .IDX_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .release_i(release_i),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int k;
        k = 0;
        while (!gnt_vld && k < 20) begin
            tick(1);
            k++;
        end
        check("wait_grant", {31'd0, gnt_vld}, 32'd1);
    endtask

    // Hold the grant for 'cycles' edges, the last of which samples release_i.
    task automatic release_after(input int cycles);
        if (cycles > 1) tick(cycles - 1);
        release_i = 1'b1;
        tick(1);
        release_i = 1'b0;
        check("bubble_gnt", {28'd0, gnt}, 32'd0);
        check("bubble_vld", {31'd0, gnt_vld}, 32'd0);
    endtask

    function automatic logic [1:0] onehot_idx(input logic [N-1:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < N; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on each new grant.
    initial begin : monitor
        logic prev_vld;
        logic [N-1:0] e;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 1'b0;
            end else begin
                check("inv_vld", {31'd0, gnt_vld}, {31'd0, |gnt});
                check("inv_onehot", {31'd0, $onehot0(gnt)}, 32'd1);
                check("inv_idx", {30'd0, gnt_idx}, {30'd0, onehot_idx(gnt)});
`ifndef ARB_TIMEOUT_EN
                check("timeout_tied", {31'd0, timeout_o}, 32'd0);
`endif
                if (gnt_vld && !prev_vld) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", {28'd0, gnt}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant", {28'd0, gnt}, {28'd0, e});
                        check("grant_idx", {30'd0, gnt_idx}, {30'd0, onehot_idx(e)});
                    end
                end
                prev_vld = gnt_vld;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench stalled");
    end

    initial begin : stim
        #2;
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_vld", {31'd0, gnt_vld}, 32'd0);
        check("rst_idx", {30'd0, gnt_idx}, 32'd0);
        check("rst_to", {31'd0, timeout_o}, 32'd0);
        tick(2);
        rst = 1'b0;

        // 1: full rotation starting at index 0
        req = 4'b1111;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        for (int i = 0; i < 5; i++) begin
            wait_grant();
            release_after(3);
        end

        // 2: lock holds against new requests
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant();
        req = 4'b1011;
        for (int i = 0; i < HOLD2; i++) begin
            tick(1);
            check("lock_gnt", {28'd0, gnt}, 32'h4);
            check("lock_idx", {30'd0, gnt_idx}, 32'd2);
        end
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        release_after(1);
        wait_grant();
        release_after(2);
        wait_grant();
        release_after(2);

        // 3: lone requester re-granted after each bubble
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(4'b0010);
            wait_grant();
            release_after(2);
        end

        // 4: owner drops req, then release in IDLE is ignored
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant();
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("drop_hold", {28'd0, gnt}, 32'h4);
        end
        release_after(1);
        release_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("idle_rel_gnt", {28'd0, gnt}, 32'd0);
            check("idle_rel_vld", {31'd0, gnt_vld}, 32'd0);
        end
        release_i = 1'b0;

        // 5: async reset mid-BUSY, pointer restored
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        wait_grant();
        tick(2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gnt", {28'd0, gnt}, 32'd0);
        check("async_rst_vld", {31'd0, gnt_vld}, 32'd0);
        check("async_rst_idx", {30'd0, gnt_idx}, 32'd0);
        tick(1);
        rst = 1'b0;
        req = 4'b1001;
        exp_q.push_back(4'b0001);
        wait_grant();
        release_after(2);
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        wait_grant();
        tick(1);
        #2 rst = 1'b1;
        #1;
        check("async_rst2_gnt", {28'd0, gnt}, 32'd0);
        tick(1);
        rst = 1'b0;
        req = 4'b0110;
        exp_q.push_back(4'b0010);
        wait_grant();
        release_after(2);

`ifdef ARB_TIMEOUT_EN
        // 6: watchdog reclaims grant after TIMEOUT cycles
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_grant();
        req = 4'b0011;
        for (int i = 0; i < TO - 1; i++) begin
            tick(1);
            check("to_hold", {28'd0, gnt}, 32'h1);
            check("to_quiet", {31'd0, timeout_o}, 32'd0);
        end
        exp_q.push_back(4'b0010);
        tick(1);
        check("to_clear", {28'd0, gnt}, 32'd0);
        check("to_pulse", {31'd0, timeout_o}, 32'd1);
        tick(1);
        check("to_pulse_end", {31'd0, timeout_o}, 32'd0);
        check("to_next", {28'd0, gnt}, 32'h2);
        release_after(2);
`endif

        req = 4'b0000;
        tick(3);
        check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
